// File: rtl/int_vector_dot_accumulator.sv
// Streaming dot-product accumulator: element-wise multiply, registered reduction,
// and per-group accumulation with a held output register and valid/ready handshakes.
module int_vector_dot_accumulator #(
   parameter int unsigned DataWidth = 8,
   parameter int unsigned Size      = 16,
   parameter int unsigned Signed    = 1,
   parameter int unsigned AccWidth  = 32,
   parameter int unsigned Saturate  = 0,
   parameter int unsigned BeatWidth = 16
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            in_valid_i,
   output logic                            in_ready_o,
   input  logic                            in_last_i,
   input  logic [Size-1:0][DataWidth-1:0]  op0_vec_i,
   input  logic [Size-1:0][DataWidth-1:0]  op1_vec_i,
   output logic                            out_valid_o,
   input  logic                            out_ready_i,
   output logic [AccWidth-1:0]             acc_o,
   output logic [BeatWidth-1:0]            beats_o,
   output logic                            overflow_o
);

   localparam int unsigned ProdWidth = 2 * DataWidth;
   localparam int unsigned LogSize   = $clog2(Size);
   localparam int unsigned SumWidth  = ProdWidth + LogSize;
   localparam int unsigned ExtWidth  = AccWidth + 1;
   localparam bit          IsSigned  = (Signed != 0);
   localparam bit          DoSat     = (Saturate != 0);

   if (Size < 2 || (Size & (Size - 1)) != 0) begin : g_bad_size
      $error("Size must be a power of 2 and at least 2");
   end
   if (AccWidth < SumWidth) begin : g_bad_acc
      $error("AccWidth must be at least SumWidth");
   end

   logic                                 stall;
   logic [Size-1:0][ProdWidth-1:0]       prod_c;
   logic [ProdWidth-1:0]                 a_ext, b_ext;
   logic [SumWidth-1:0]                  sum_c;
   logic [ExtWidth-1:0]                  ext_sum_c, base_c, total_c;
   logic [AccWidth-1:0]                  acc_next_c;
   logic [BeatWidth-1:0]                 cnt_next_c;
   logic                                 ovf_add_c, ovf_next_c;

   logic [Size-1:0][ProdWidth-1:0]       p_prod_q;
   logic                                 p_valid_q, p_last_q;
   logic [SumWidth-1:0]                  t_sum_q;
   logic                                 t_valid_q, t_last_q;
   logic [AccWidth-1:0]                  acc_q;
   logic [BeatWidth-1:0]                 cnt_q;
   logic                                 ovf_q, first_q;
   logic                                 a_valid_q, a_last_q;

   assign stall      = out_valid_o & ~out_ready_i;
   assign in_ready_o = ~stall;

   // Operands are extended to ProdWidth so the low half of the product is exact
   // for both signed and unsigned operands.
   always_comb begin
      a_ext  = '0;
      b_ext  = '0;
      prod_c = '0;
      for (int i = 0; i < int'(Size); i++) begin
         a_ext     = {{DataWidth{IsSigned & op0_vec_i[i][DataWidth-1]}}, op0_vec_i[i]};
         b_ext     = {{DataWidth{IsSigned & op1_vec_i[i][DataWidth-1]}}, op1_vec_i[i]};
         prod_c[i] = a_ext * b_ext;
      end
   end

   // Full-precision reduction of the registered products.
   always_comb begin
      sum_c = '0;
      for (int i = 0; i < int'(Size); i++) begin
         sum_c = sum_c + {{LogSize{IsSigned & p_prod_q[i][ProdWidth-1]}}, p_prod_q[i]};
      end
   end

   // Accumulate one extra bit wide so overflow is visible in the top two bits.
   always_comb begin
      ext_sum_c  = {{(ExtWidth-SumWidth){IsSigned & t_sum_q[SumWidth-1]}}, t_sum_q};
      base_c     = first_q ? '0 : {IsSigned & acc_q[AccWidth-1], acc_q};
      total_c    = base_c + ext_sum_c;
      ovf_add_c  = IsSigned ? (total_c[AccWidth] ^ total_c[AccWidth-1]) : total_c[AccWidth];
      acc_next_c = total_c[AccWidth-1:0];
      if (DoSat && ovf_add_c) begin
         if (!IsSigned)             acc_next_c = '1;
         else if (total_c[AccWidth]) acc_next_c = {1'b1, {(AccWidth-1){1'b0}}};
         else                        acc_next_c = {1'b0, {(AccWidth-1){1'b1}}};
      end
      cnt_next_c = first_q ? BeatWidth'(1) : ((&cnt_q) ? cnt_q : cnt_q + BeatWidth'(1));
      ovf_next_c = (~first_q & ovf_q) | ovf_add_c;
   end

   // Pipeline and accumulator; the whole chain freezes while a result is refused.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         p_prod_q    <= '0;
         p_valid_q   <= 1'b0;
         p_last_q    <= 1'b0;
         t_sum_q     <= '0;
         t_valid_q   <= 1'b0;
         t_last_q    <= 1'b0;
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         first_q     <= 1'b1;
         a_valid_q   <= 1'b0;
         a_last_q    <= 1'b0;
         out_valid_o <= 1'b0;
         acc_o       <= '0;
         beats_o     <= '0;
         overflow_o  <= 1'b0;
      end else if (!stall) begin
         p_valid_q <= in_valid_i;
         p_last_q  <= in_valid_i & in_last_i;
         if (in_valid_i) p_prod_q <= prod_c;
         t_valid_q <= p_valid_q;
         t_last_q  <= p_last_q;
         if (p_valid_q) t_sum_q <= sum_c;
         a_valid_q <= t_valid_q;
         a_last_q  <= t_last_q;
         if (t_valid_q) begin
            acc_q   <= acc_next_c;
            cnt_q   <= cnt_next_c;
            ovf_q   <= ovf_next_c;
            first_q <= t_last_q;
         end
         // Output register reads the closed group while the next group may start in acc_q.
         out_valid_o <= a_valid_q & a_last_q;
         if (a_valid_q & a_last_q) begin
            acc_o      <= acc_q;
            beats_o    <= cnt_q;
            overflow_o <= ovf_q;
         end
      end
   end

endmodule

// File: tb/tb_int_vector_dot_accumulator.sv
// Directed bench for int_vector_dot_accumulator: four parameterisations share one
// input stream; expected values are hand-computed constants.
module tb_int_vector_dot_accumulator;

   logic              clk_i, rst_i, in_valid_i, in_last_i, out_ready_i;
   logic [3:0][7:0]   op0, op1;

   logic              m_rdy, m_ov, m_ovf;
   logic [31:0]       m_acc;
   logic [15:0]       m_beats;
   logic              s_rdy, s_ov, s_ovf;
   logic [17:0]       s_acc;
   logic [15:0]       s_beats;
   logic              w_rdy, w_ov, w_ovf;
   logic [17:0]       w_acc;
   logic [15:0]       w_beats;
   logic              u_rdy, u_ov, u_ovf;
   logic [31:0]       u_acc;
   logic [15:0]       u_beats;

   int total = 0;
   int bad   = 0;

   localparam logic [31:0] V1234 = {8'd4, 8'd3, 8'd2, 8'd1};
   localparam logic [31:0] V5678 = {8'd8, 8'd7, 8'd6, 8'd5};
   localparam logic [31:0] ONES  = 32'h0101_0101;
   localparam logic [31:0] TWOS  = 32'h0202_0202;
   localparam logic [31:0] M128  = 32'h8080_8080;
   localparam logic [31:0] ALLFF = 32'hFFFF_FFFF;
   localparam logic [31:0] TENS  = 32'h0A0A_0A0A;

   int_vector_dot_accumulator #(.DataWidth(8), .Size(4), .Signed(1), .AccWidth(32),
      .Saturate(0), .BeatWidth(16)) dut_main (
      .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(m_rdy),
      .in_last_i(in_last_i), .op0_vec_i(op0), .op1_vec_i(op1), .out_valid_o(m_ov),
      .out_ready_i(out_ready_i), .acc_o(m_acc), .beats_o(m_beats), .overflow_o(m_ovf));

   int_vector_dot_accumulator #(.DataWidth(8), .Size(4), .Signed(1), .AccWidth(18),
      .Saturate(1), .BeatWidth(16)) dut_sat (
      .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(s_rdy),
      .in_last_i(in_last_i), .op0_vec_i(op0), .op1_vec_i(op1), .out_valid_o(s_ov),
      .out_ready_i(out_ready_i), .acc_o(s_acc), .beats_o(s_beats), .overflow_o(s_ovf));

   int_vector_dot_accumulator #(.DataWidth(8), .Size(4), .Signed(1), .AccWidth(18),
      .Saturate(0), .BeatWidth(16)) dut_wrap (
      .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(w_rdy),
      .in_last_i(in_last_i), .op0_vec_i(op0), .op1_vec_i(op1), .out_valid_o(w_ov),
      .out_ready_i(out_ready_i), .acc_o(w_acc), .beats_o(w_beats), .overflow_o(w_ovf));

   int_vector_dot_accumulator #(.DataWidth(8), .Size(4), .Signed(0), .AccWidth(32),
      .Saturate(0), .BeatWidth(16)) dut_uns (
      .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(u_rdy),
      .in_last_i(in_last_i), .op0_vec_i(op0), .op1_vec_i(op1), .out_valid_o(u_ov),
      .out_ready_i(out_ready_i), .acc_o(u_acc), .beats_o(u_beats), .overflow_o(u_ovf));

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Present one beat and hold it until an edge on which the block was ready.
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic last);
      logic rdy;
      int   n;
      op0 = a; op1 = b; in_last_i = last; in_valid_i = 1'b1; n = 0;
      do begin
         rdy = m_rdy;
         @(posedge clk_i); #1;
         n++;
      end while (!rdy && n < 50);
      if (!rdy) chk("send_timeout", 64'(rdy), 64'd1);
      in_valid_i = 1'b0;
      in_last_i  = 1'b0;
   endtask

   task automatic wait_out(input int max);
      int n;
      n = 0;
      while (!m_ov && n < max) begin
         @(posedge clk_i); #1;
         n++;
      end
      chk("out_valid_seen", 64'(m_ov), 64'd1);
   endtask

   logic [31:0] b2b_exp [4];

   initial begin
      rst_i = 1'b1; in_valid_i = 1'b0; in_last_i = 1'b0; out_ready_i = 1'b1;
      op0 = '0; op1 = '0;
      #22 rst_i = 1'b0;
      @(posedge clk_i); #1;
      chk("rst_valid", 64'(m_ov), 64'd0);
      chk("rst_acc", 64'(m_acc), 64'd0);
      chk("rst_beats", 64'(m_beats), 64'd0);
      chk("rst_ovf", 64'(m_ovf), 64'd0);
      chk("rst_ready", 64'(m_rdy), 64'd1);

      // single beat: 1*5+2*6+3*7+4*8 = 70, visible three edges after acceptance
      send(V1234, V5678, 1'b1);
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      chk("lat_early", 64'(m_ov), 64'd0);
      @(posedge clk_i); #1;
      chk("lat_valid", 64'(m_ov), 64'd1);
      chk("single_acc", 64'(m_acc), 64'd70);
      chk("single_beats", 64'(m_beats), 64'd1);
      chk("single_ovf", 64'(m_ovf), 64'd0);

      // two beats of 4 * (-128 * -128) = 65536 each
      send(M128, M128, 1'b0);
      send(M128, M128, 1'b1);
      wait_out(10);
      chk("ext32_acc", 64'(m_acc), 64'd131072);
      chk("ext32_ovf", 64'(m_ovf), 64'd0);
      chk("ext32_beats", 64'(m_beats), 64'd2);
      chk("sat18_acc", 64'(s_acc), 64'd131071);
      chk("sat18_ovf", 64'(s_ovf), 64'd1);
      chk("sat18_beats", 64'(s_beats), 64'd2);
      chk("wrap18_acc", 64'(w_acc), 64'h2_0000);
      chk("wrap18_ovf", 64'(w_ovf), 64'd1);

      // all-ones operands: 4*255*255 unsigned, 4*(-1*-1) signed; overflow cleared
      send(ALLFF, ALLFF, 1'b1);
      wait_out(10);
      chk("uns_acc", 64'(u_acc), 64'd260100);
      chk("sgn_ff_acc", 64'(m_acc), 64'd4);
      chk("sat18_ovf_clear", 64'(s_ovf), 64'd0);

      // back-to-back single-beat groups: 10, 6, -4, 400
      b2b_exp[0] = 32'd10; b2b_exp[1] = 32'd6; b2b_exp[2] = 32'hFFFF_FFFC; b2b_exp[3] = 32'd400;
      send(V1234, ONES, 1'b1);
      send(32'h0000_0002, 32'h0000_0003, 1'b1);
      send(ALLFF, ONES, 1'b1);
      send(TENS, TENS, 1'b1);
      wait_out(10);
      chk("b2b_acc0", 64'(m_acc), 64'(b2b_exp[0]));
      for (int i = 1; i < 4; i++) begin
         @(posedge clk_i); #1;
         chk("b2b_valid", 64'(m_ov), 64'd1);
         chk("b2b_acc", 64'(m_acc), 64'(b2b_exp[i]));
         chk("b2b_beats", 64'(m_beats), 64'd1);
      end
      @(posedge clk_i); #1;
      chk("b2b_drained", 64'(m_ov), 64'd0);

      // backpressure: group A = 2 beats of 4 (8), group B = 3 beats of 8 (24)
      out_ready_i = 1'b0;
      send(ONES, ONES, 1'b0);
      send(ONES, ONES, 1'b1);
      send(TWOS, ONES, 1'b0);
      send(TWOS, ONES, 1'b0);
      send(TWOS, ONES, 1'b1);
      for (int i = 0; i < 5; i++) begin
         chk("bp_ready_low", 64'(m_rdy), 64'd0);
         chk("bp_held_valid", 64'(m_ov), 64'd1);
         chk("bp_held_acc", 64'(m_acc), 64'd8);
         chk("bp_held_beats", 64'(m_beats), 64'd2);
         @(posedge clk_i); #1;
      end
      out_ready_i = 1'b1;
      @(posedge clk_i); #1;
      chk("bp_ready_back", 64'(m_rdy), 64'd1);
      wait_out(10);
      chk("bp_b_acc", 64'(m_acc), 64'd24);
      chk("bp_b_beats", 64'(m_beats), 64'd3);
      @(posedge clk_i); #1;

      // reset with a held result and two partial beats in flight
      out_ready_i = 1'b0;
      send(V1234, V5678, 1'b1);
      send(ONES, ONES, 1'b0);
      send(ONES, ONES, 1'b0);
      wait_out(10);
      chk("pre_rst_acc", 64'(m_acc), 64'd70);
      #2 rst_i = 1'b1;
      #1;
      chk("arst_valid", 64'(m_ov), 64'd0);
      chk("arst_acc", 64'(m_acc), 64'd0);
      chk("arst_beats", 64'(m_beats), 64'd0);
      chk("arst_ovf", 64'(m_ovf), 64'd0);
      chk("arst_ready", 64'(m_rdy), 64'd1);
      #1 rst_i = 1'b0;
      out_ready_i = 1'b1;
      send(ONES, ONES, 1'b1);
      wait_out(10);
      chk("post_rst_acc", 64'(m_acc), 64'd4);
      chk("post_rst_beats", 64'(m_beats), 64'd1);
      chk("post_rst_ovf", 64'(m_ovf), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/int_vector_dot_accumulator.md
# int_vector_dot_accumulator

Streaming, pipelined dot-product accumulator. Each accepted beat delivers two `Size`-element integer vectors. The block multiplies them element-wise, reduces the products through a registered adder tree, and accumulates the per-beat sums across a group of beats delimited by `in_last_i`. It sits behind the vector multiplier/adder-tree datapath as the reduction engine for matrix-vector and convolution layers, with valid/ready handshakes on both sides.

## Interface
Parameters:
- `DataWidth`, 8: element width of each operand.
- `Size`, 16: elements per vector. Must be a power of 2 and ≥2; elaboration `$error` otherwise.
- `Signed`, 1: 0 = unsigned operands, 1 = two's-complement operands.
- `AccWidth`, 32: accumulator/result width. Must be ≥ `SumWidth`; elaboration `$error` otherwise.
- `Saturate`, 0: 0 = wrap on overflow, 1 = clamp to the `AccWidth` range.
- `BeatWidth`, 16: width of the beat counter.
- Derived: `ProdWidth` = 2·`DataWidth`; `SumWidth` = `ProdWidth` + $clog2(`Size`).

Ports:
- `clk_i` in 1: clock; all state updates on rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `in_valid_i` in 1: input beat valid.
- `in_ready_o` out 1: block accepts a beat.
- `in_last_i` in 1: beat closes the current group.
- `op0_vec_i` in `Size`×`DataWidth`: operand vector 0.
- `op1_vec_i` in `Size`×`DataWidth`: operand vector 1.
- `out_valid_o` out 1: result valid.
- `out_ready_i` in 1: consumer accepts the result.
- `acc_o` out `AccWidth`: group dot-product result.
- `beats_o` out `BeatWidth`: number of beats in the group. Saturates at all-ones.
- `overflow_o` out 1: sticky flag. Set if any accumulation in the group exceeded the `AccWidth` range.

## Operation
- Three register stages: P (products), T (tree sum), A (accumulate/output). Each stage carries `valid` and `last`.
- Stall rule: `stall = out_valid_o & ~out_ready_i`.
  - `in_ready_o = ~stall` (combinational).
  - All stages hold while `stall` is high; otherwise all stages advance every cycle.
  - Bubbles propagate as invalid.
- P stage: `Size` products, each `ProdWidth` wide. Signed or unsigned multiply per `Signed`.
- T stage: full-precision sum of all products, `SumWidth` wide, sign- or zero-extended per `Signed`.
- A stage: on a valid T beat, `next = (first ? 0 : acc) + ext(T)`.
  - The add is computed at `AccWidth`+1 bits. Overflow = result outside the signed (or unsigned) `AccWidth` range.
  - `Saturate=1`: clamp to the max/min of that range. `Saturate=0`: keep the low `AccWidth` bits.
  - The overflow flag and beat counter accumulate in parallel with the sum.
- On a valid T beat with `last` set:
  - Load `acc_o`, `beats_o`, `overflow_o` with the group values.
  - Set `out_valid_o`.
  - Set `first`, clearing the accumulator, counter and flag for the next group.
- Output handshake: the result is consumed when `out_valid_o & out_ready_i`. `out_valid_o` clears, unless a new last beat loads on the same edge, in which case the output reloads and stays valid.
- Outputs are stable while `out_valid_o & ~out_ready_i`.
- Groups have no maximum length. A zero-beat group is impossible: the last beat is itself counted.

## Timing
- Reset values:
  - `out_valid_o`=0, `acc_o`=0, `beats_o`=0, `overflow_o`=0.
  - All stage valids 0; `first`=1.
  - `in_ready_o`=1.
- Latency: a last beat accepted at edge k produces `out_valid_o`=1 after edge k+3. Stall cycles add to this.
- Throughput: one beat per cycle while unstalled. Single-beat groups yield one result per cycle when `out_ready_i` stays 1.
- `in_ready_o` falls in the same cycle `out_valid_o` is high with `out_ready_i` low. No accepted beat is ever dropped or duplicated.
- `rst_i` asserted mid-group discards all in-flight beats and the partial accumulation immediately. This is asynchronous; it does not wait for an edge.
- `in_last_i`, `op0_vec_i` and `op1_vec_i` are ignored when `in_valid_i & in_ready_o` is low.

## Test plan
Defaults `Size`=4, `DataWidth`=8, `Signed`=1 unless noted.
- Single-beat group: `op0`={1,2,3,4}, `op1`={5,6,7,8}, last=1.
  - Expect `acc_o`=70, `beats_o`=1, `overflow_o`=0.
  - `out_valid_o` rises 3 edges after acceptance.
- Signed extremes, `AccWidth`=18: two beats of all −128 × −128 (65536 per beat).
  - With `Saturate`=1: expect 131071, overflow 1, beats 2.
  - With `Saturate`=0: expect −131072, overflow 1.
  - With `AccWidth`=32: expect 131072, overflow 0.
- Unsigned, `Signed`=0: one beat, all 255×255.
  - Expect `acc_o`=260100.
- Back-to-back single-beat groups with `out_ready_i`=1: expect one result per cycle, in order, with no bubbles.
- Backpressure: continuous beats with `out_ready_i` held 0 for 5 cycles.
  - `in_ready_o` drops while the result is held.
  - Results are unchanged and in order after release, and the beat count is preserved.
- Reset mid-group: assert `rst_i` after 2 of 3 beats.
  - All outputs go to 0 immediately.
  - The next 1-beat group of {1,1,1,1}·{1,1,1,1} returns `acc_o`=4, `beats_o`=1.
